// File: rtl/tb_clk_sequencer_if.sv
// Control and status bundle for the clock/reset sequencer.
// master: the controller driving start/stop/config; slave: the sequencer.
interface tb_clk_sequencer_if #(
   parameter int unsigned CNT_W = 16,
   parameter int unsigned DIV_W = 8
);
   logic             start;
   logic             stop;
   logic [CNT_W-1:0] rst_cycles;
   logic [CNT_W-1:0] settle_cycles;
   logic [CNT_W-1:0] run_cycles;
   logic [DIV_W-1:0] div_ratio;
   logic             dut_reset_n;
   logic             clk_en;
   logic             div_tick;
   logic             busy;
   logic             done;
   logic [CNT_W-1:0] run_count;

   modport master (
      output start, stop, rst_cycles, settle_cycles, run_cycles, div_ratio,
      input  dut_reset_n, clk_en, div_tick, busy, done, run_count
   );

   modport slave (
      input  start, stop, rst_cycles, settle_cycles, run_cycles, div_ratio,
      output dut_reset_n, clk_en, div_tick, busy, done, run_count
   );
endinterface

// File: rtl/tb_clk_sequencer.sv
// Clock/reset sequencer: holds a DUT in reset, lets it settle, then enables its
// clock for a programmed number of cycles while emitting a divided tick.
// All outputs are registered and derived from the next state, so they take
// their new value in the same cycle the state is entered.
module tb_clk_sequencer #(
   parameter int unsigned CNT_W = 16,
   parameter int unsigned DIV_W = 8
) (
   input logic               clk,
   input logic               reset_n,
   tb_clk_sequencer_if.slave bus
);

   localparam logic [CNT_W-1:0] CntOne = CNT_W'(1);
   localparam logic [DIV_W-1:0] DivOne = DIV_W'(1);

   typedef enum logic [2:0] {StIdle, StReset, StSettle, StRun, StDone} state_e;

   state_e           state_q, state_d;
   logic [CNT_W-1:0] rst_cfg_q, rst_cfg_d;
   logic [CNT_W-1:0] settle_cfg_q, settle_cfg_d;
   logic [CNT_W-1:0] run_cfg_q, run_cfg_d;
   logic [DIV_W-1:0] div_cfg_q, div_cfg_d;
   logic [CNT_W-1:0] phase_q, phase_d;
   logic [CNT_W-1:0] run_count_q, run_count_d;
   logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
   logic             dut_reset_n_q, dut_reset_n_d;
   logic             clk_en_q, clk_en_d;
   logic             div_tick_q, div_tick_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;

   logic             accept;
   logic [CNT_W-1:0] rst_len;
   logic [CNT_W-1:0] run_count_inc;
   logic             div_short;

   // Next-state, counter and registered-output computation.
   always_comb begin
      state_d      = state_q;
      rst_cfg_d    = rst_cfg_q;
      settle_cfg_d = settle_cfg_q;
      run_cfg_d    = run_cfg_q;
      div_cfg_d    = div_cfg_q;
      phase_d      = phase_q;
      run_count_d  = run_count_q;
      div_cnt_d    = div_cnt_q;
      div_tick_d   = 1'b0;
      accept       = 1'b0;

      // A zero reset length still gives one cycle of reset.
      rst_len       = (rst_cfg_q == '0) ? CntOne : rst_cfg_q;
      run_count_inc = (run_count_q == '1) ? run_count_q : run_count_q + CntOne;
      div_short     = (div_cfg_q <= DivOne);

      unique case (state_q)
         StIdle: begin
            if (bus.start && !bus.stop) accept = 1'b1;
         end
         StReset: begin
            if (bus.stop) begin
               state_d = StIdle;
            end else if (phase_q == rst_len - CntOne) begin
               phase_d = '0;
               state_d = (settle_cfg_q != '0) ? StSettle : StRun;
            end else begin
               phase_d = phase_q + CntOne;
            end
         end
         StSettle: begin
            if (bus.stop) begin
               state_d = StIdle;
            end else if (phase_q == settle_cfg_q - CntOne) begin
               phase_d = '0;
               state_d = StRun;
            end else begin
               phase_d = phase_q + CntOne;
            end
         end
         StRun: begin
            run_count_d = run_count_inc;
            if (bus.stop) begin
               state_d = StIdle;
            end else if (run_cfg_q != '0 && phase_q == run_cfg_q - CntOne) begin
               phase_d = '0;
               state_d = StDone;
            end else begin
               phase_d = phase_q + CntOne;
            end
         end
         StDone: begin
            if (bus.stop) begin
               state_d     = StIdle;
               run_count_d = '0;
            end else if (bus.start) begin
               accept = 1'b1;
            end
         end
         default: state_d = StIdle;
      endcase

      if (accept) begin
         state_d      = StReset;
         phase_d      = '0;
         run_count_d  = '0;
         rst_cfg_d    = bus.rst_cycles;
         settle_cfg_d = bus.settle_cycles;
         run_cfg_d    = bus.run_cycles;
         div_cfg_d    = bus.div_ratio;
      end

      // Divider restarts at 0 on RUN entry; tick is aligned to the counter value entered.
      if (state_d == StRun) begin
         if (state_q != StRun) begin
            div_cnt_d = '0;
         end else if (div_short || div_cnt_q == div_cfg_q - DivOne) begin
            div_cnt_d = '0;
         end else begin
            div_cnt_d = div_cnt_q + DivOne;
         end
         div_tick_d = div_short || (div_cnt_d == div_cfg_q - DivOne);
      end else begin
         div_cnt_d = '0;
      end

      dut_reset_n_d = (state_d != StReset);
      clk_en_d      = (state_d == StRun);
      busy_d        = (state_d == StReset) || (state_d == StSettle) || (state_d == StRun);
      done_d        = (state_d == StDone);
   end

   // State, configuration, counters and registered outputs.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q       <= StIdle;
         rst_cfg_q     <= '0;
         settle_cfg_q  <= '0;
         run_cfg_q     <= '0;
         div_cfg_q     <= '0;
         phase_q       <= '0;
         run_count_q   <= '0;
         div_cnt_q     <= '0;
         dut_reset_n_q <= 1'b0;
         clk_en_q      <= 1'b0;
         div_tick_q    <= 1'b0;
         busy_q        <= 1'b0;
         done_q        <= 1'b0;
      end else begin
         state_q       <= state_d;
         rst_cfg_q     <= rst_cfg_d;
         settle_cfg_q  <= settle_cfg_d;
         run_cfg_q     <= run_cfg_d;
         div_cfg_q     <= div_cfg_d;
         phase_q       <= phase_d;
         run_count_q   <= run_count_d;
         div_cnt_q     <= div_cnt_d;
         dut_reset_n_q <= dut_reset_n_d;
         clk_en_q      <= clk_en_d;
         div_tick_q    <= div_tick_d;
         busy_q        <= busy_d;
         done_q        <= done_d;
      end
   end

   assign bus.dut_reset_n = dut_reset_n_q;
   assign bus.clk_en      = clk_en_q;
   assign bus.div_tick    = div_tick_q;
   assign bus.busy        = busy_q;
   assign bus.done        = done_q;
   assign bus.run_count   = run_count_q;

endmodule

// File: tb/tb_tb_clk_sequencer.sv
// Self-checking bench for tb_clk_sequencer: table of full sequences plus
// hand-written stop, restart, start-while-busy and async-reset cases.
module tb_tb_clk_sequencer;

   localparam int unsigned CNT_W = 16;
   localparam int unsigned DIV_W = 8;

   logic clk = 1'b0;
   logic reset_n = 1'b0;
   int   total = 0;
   int   bad = 0;

   always #5 clk = ~clk;

   tb_clk_sequencer_if #(.CNT_W(CNT_W), .DIV_W(DIV_W)) bus ();

   tb_clk_sequencer #(.CNT_W(CNT_W), .DIV_W(DIV_W)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus)
   );

   typedef struct {
      int rst;
      int settle;
      int run;
      int div;
      int low;   // cycles with dut_reset_n low
      int en;    // cycles with clk_en high
      int mask;  // bit i set = div_tick on RUN cycle i+1
      int bsy;   // cycles with busy high
   } vec_t;

   vec_t vecs[5];

   task automatic check(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic set_cfg(input int r, input int s, input int n, input int d);
      bus.rst_cycles    = CNT_W'(r);
      bus.settle_cycles = CNT_W'(s);
      bus.run_cycles    = CNT_W'(n);
      bus.div_ratio     = DIV_W'(d);
   endtask

   // Start a sequence from IDLE/DONE, scramble the config inputs, and measure it.
   task automatic run_vec(input vec_t v, input string tag);
      int low, en, mask, bsy, idx, stray;
      bit fin;
      low = 0; en = 0; mask = 0; bsy = 0; idx = 0; stray = 0; fin = 1'b0;
      @(negedge clk);
      set_cfg(v.rst, v.settle, v.run, v.div);
      bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      set_cfg(9, 9, 9, 9);
      for (int c = 0; c < 300; c++) begin
         if (bus.done) begin
            fin = 1'b1;
            break;
         end
         if (!bus.dut_reset_n) low++;
         if (bus.busy) bsy++;
         if (bus.div_tick && !bus.clk_en) stray++;
         if (bus.clk_en) begin
            if (bus.div_tick) mask |= (1 << idx);
            idx++;
            en++;
         end
         @(negedge clk);
      end
      check({tag, " reached done"}, int'(fin), 1);
      check({tag, " reset low cycles"}, low, v.low);
      check({tag, " clk_en cycles"}, en, v.en);
      check({tag, " div_tick pattern"}, mask, v.mask);
      check({tag, " busy cycles"}, bsy, v.bsy);
      check({tag, " run_count"}, int'(bus.run_count), v.run);
      check({tag, " stray div_tick"}, stray + int'(bus.div_tick) + int'(bus.clk_en), 0);
   endtask

   task automatic wait_clk_en(output bit ok);
      ok = 1'b0;
      for (int c = 0; c < 200; c++) begin
         if (bus.clk_en) begin
            ok = 1'b1;
            break;
         end
         @(negedge clk);
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      bit ok;
      int rc_before;

      vecs[0] = '{rst: 3, settle: 2, run: 5, div: 2, low: 3, en: 5, mask: 'h0A, bsy: 10};
      vecs[1] = '{rst: 0, settle: 0, run: 1, div: 2, low: 1, en: 1, mask: 'h00, bsy: 2};
      vecs[2] = '{rst: 1, settle: 0, run: 4, div: 0, low: 1, en: 4, mask: 'h0F, bsy: 5};
      vecs[3] = '{rst: 2, settle: 3, run: 7, div: 3, low: 2, en: 7, mask: 'h24, bsy: 12};
      vecs[4] = '{rst: 4, settle: 1, run: 6, div: 1, low: 4, en: 6, mask: 'h3F, bsy: 11};

      bus.start = 1'b0;
      bus.stop  = 1'b0;
      set_cfg(0, 0, 0, 0);

      // Reset values while reset_n is low.
      #12;
      check("reset dut_reset_n", int'(bus.dut_reset_n), 0);
      check("reset clk_en", int'(bus.clk_en), 0);
      check("reset div_tick", int'(bus.div_tick), 0);
      check("reset busy", int'(bus.busy), 0);
      check("reset done", int'(bus.done), 0);
      check("reset run_count", int'(bus.run_count), 0);
      @(negedge clk);
      reset_n = 1'b1;
      @(negedge clk);
      check("post-reset dut_reset_n", int'(bus.dut_reset_n), 1);
      check("post-reset busy", int'(bus.busy), 0);

      // Table of full sequences, chained from DONE to DONE.
      for (int i = 0; i < 5; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

      // Stop from DONE: back to IDLE with run_count cleared.
      @(negedge clk);
      bus.stop = 1'b1;
      @(negedge clk);
      bus.stop = 1'b0;
      check("stop-in-done done", int'(bus.done), 0);
      check("stop-in-done run_count", int'(bus.run_count), 0);

      // Free-running RUN stopped after 10 cycles.
      @(negedge clk);
      set_cfg(1, 0, 0, 3);
      bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      wait_clk_en(ok);
      check("free-run reached RUN", int'(ok), 1);
      repeat (9) @(negedge clk);
      check("free-run count before stop", int'(bus.run_count), 9);
      check("free-run still enabled", int'(bus.clk_en), 1);
      bus.stop = 1'b1;
      @(negedge clk);
      bus.stop = 1'b0;
      check("stop-in-run clk_en", int'(bus.clk_en), 0);
      check("stop-in-run busy", int'(bus.busy), 0);
      check("stop-in-run done", int'(bus.done), 0);
      check("stop-in-run dut_reset_n", int'(bus.dut_reset_n), 1);
      @(negedge clk);
      check("idle stays idle", int'(bus.busy), 0);

      // Start and stop together from DONE: stop wins.
      run_vec(vecs[1], "pre-collision");
      @(negedge clk);
      bus.start = 1'b1;
      bus.stop  = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      bus.stop  = 1'b0;
      check("start+stop busy", int'(bus.busy), 0);
      check("start+stop done", int'(bus.done), 0);
      check("start+stop run_count", int'(bus.run_count), 0);
      check("start+stop dut_reset_n", int'(bus.dut_reset_n), 1);

      // Start during RUN is ignored.
      @(negedge clk);
      set_cfg(2, 1, 0, 4);
      bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      wait_clk_en(ok);
      check("busy-start reached RUN", int'(ok), 1);
      repeat (2) @(negedge clk);
      rc_before = int'(bus.run_count);
      bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      check("busy-start clk_en", int'(bus.clk_en), 1);
      check("busy-start dut_reset_n", int'(bus.dut_reset_n), 1);
      check("busy-start run_count", int'(bus.run_count), rc_before + 1);
      bus.stop = 1'b1;
      @(negedge clk);
      bus.stop = 1'b0;

      // Async reset during SETTLE, then a full sequence afterwards.
      @(negedge clk);
      set_cfg(2, 5, 3, 1);
      bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      ok = 1'b0;
      for (int c = 0; c < 50; c++) begin
         if (bus.busy && bus.dut_reset_n && !bus.clk_en) begin
            ok = 1'b1;
            break;
         end
         @(negedge clk);
      end
      check("reached SETTLE", int'(ok), 1);
      #2;
      reset_n = 1'b0;
      #1;
      check("async reset dut_reset_n", int'(bus.dut_reset_n), 0);
      check("async reset busy", int'(bus.busy), 0);
      check("async reset clk_en", int'(bus.clk_en), 0);
      check("async reset done", int'(bus.done), 0);
      @(negedge clk);
      reset_n = 1'b1;
      @(negedge clk);
      run_vec('{rst: 2, settle: 5, run: 3, div: 1, low: 2, en: 3, mask: 'h07, bsy: 10},
              "after-reset");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
